// File: rtl/ripple_cnt_pkg.sv
// Shared definitions for the ripple up/down counter family.
package ripple_cnt_pkg;

    localparam int unsigned DefaultWidth = 3;

    typedef logic [DefaultWidth-1:0] count_t;

    // A shift of 32 yields 0, so the subtraction still gives all ones at width 32.
    function automatic logic [31:0] all_ones(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/jk_ff_ar.sv
// Negative-edge JK flip-flop with asynchronous active-high preset.
module jk_ff_ar (
    input  logic clk_i,
    input  logic set_i,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);

    logic q_q;

    always_ff @(negedge clk_i or posedge set_i) begin
        if (set_i) begin
            q_q <= 1'b1;
        end else begin
            case ({j_i, k_i})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ripple_down_counter.sv
// Ripple down counter from negedge JK stages, re-timed on posedge clk with tc/underflow flags.
// Define RIPPLE_DOWN_STOP_AT_ZERO_EN to saturate at zero instead of wrapping.
module ripple_down_counter
    import ripple_cnt_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             underflow_o
);

    localparam logic [31:0]      AllOnesW = all_ones(WIDTH);
    localparam logic [WIDTH-1:0] AllOnes  = AllOnesW[WIDTH-1:0];

    logic [WIDTH-1:0] raw;
    logic             stage0_jk;

`ifdef RIPPLE_DOWN_STOP_AT_ZERO_EN
    assign stage0_jk = en_i & (raw != '0);
`else
    assign stage0_jk = en_i;
`endif

    // Stage i toggles when bit i-1 rises, i.e. on a borrow out of the lower bits.
    for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_stage
        if (gi == 0) begin : g_first
            jk_ff_ar u_ff (
                .clk_i (clk),
                .set_i (rst),
                .j_i   (stage0_jk),
                .k_i   (stage0_jk),
                .q_o   (raw[0])
            );
        end else begin : g_rest
            logic stage_clk;
            assign stage_clk = ~raw[gi-1];
            jk_ff_ar u_ff (
                .clk_i (stage_clk),
                .set_i (rst),
                .j_i   (1'b1),
                .k_i   (1'b1),
                .q_o   (raw[gi])
            );
        end
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             underflow_q, underflow_d;

    always_comb begin
        count_d     = raw;
        tc_d        = (raw == '0);
`ifdef RIPPLE_DOWN_STOP_AT_ZERO_EN
        underflow_d = 1'b0;
`else
        underflow_d = (count_q == '0) && (raw == AllOnes);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= AllOnes;
            tc_q        <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            tc_q        <= tc_d;
            underflow_q <= underflow_d;
        end
    end

    assign count_o     = count_q;
    assign tc_o        = tc_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_ripple_down_counter.sv
// Self-checking bench: WIDTH=3 and WIDTH=4 instances share clk/rst, scoreboard-checked per posedge.
module tb_ripple_down_counter;

`ifdef RIPPLE_DOWN_STOP_AT_ZERO_EN
    localparam bit StopAtZero = 1'b1;
`else
    localparam bit StopAtZero = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en3 = 1'b0;
    logic       en4 = 1'b0;
    logic [2:0] count3;
    logic       tc3, uf3;
    logic [3:0] count4;
    logic       tc4, uf4;

    ripple_down_counter #(.WIDTH(3)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en3),
        .count_o     (count3),
        .tc_o        (tc3),
        .underflow_o (uf3)
    );

    ripple_down_counter #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en4),
        .count_o     (count4),
        .tc_o        (tc4),
        .underflow_o (uf4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         dut;
        logic [3:0] count;
        logic       tc;
        logic       uf;
        string      name;
    } exp_t;

    typedef struct {
        logic       en;
        logic [3:0] count;
        logic       tc;
        logic       uf;
    } vec_t;

    exp_t       sb_q[$];
    vec_t       vecs[12];
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [3:0] m3 = 4'd7;
    logic [3:0] m4 = 4'd15;

    task automatic check_out(input exp_t e);
        logic [3:0] ac;
        logic       at, au;
        if (e.dut == 3) begin
            ac = {1'b0, count3}; at = tc3; au = uf3;
        end else begin
            ac = count4; at = tc4; au = uf4;
        end
        tests_run++;
        if (ac !== e.count || at !== e.tc || au !== e.uf) begin
            tests_failed++;
            $display("FAIL %s dut%0d @%0t: got count=%0d tc=%0b uf=%0b, expected count=%0d tc=%0b uf=%0b",
                     e.name, e.dut, $time, ac, at, au, e.count, e.tc, e.uf);
        end
    endtask

    task automatic pop_check();
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard_empty @%0t: got no entry, expected one", $time);
        end else begin
            check_out(sb_q.pop_front());
        end
    endtask

    // Reference: one decrement per enabled negedge, flags derived from old/new value.
    task automatic model_push(input int dut, input logic en, input string name);
        logic [3:0] mask, prev, nxt;
        exp_t       e;
        mask = (dut == 3) ? 4'h7 : 4'hF;
        prev = (dut == 3) ? m3 : m4;
        nxt  = prev;
        if (en && !(StopAtZero && prev == 4'd0)) nxt = (prev - 4'd1) & mask;
        e.dut   = dut;
        e.count = nxt;
        e.tc    = (nxt == 4'd0);
        e.uf    = !StopAtZero && (prev == 4'd0) && (nxt == mask);
        e.name  = name;
        sb_q.push_back(e);
        if (dut == 3) m3 = nxt;
        else          m4 = nxt;
    endtask

    task automatic cycle(input logic e3, input logic e4);
        en3 = e3;
        en4 = e4;
        @(negedge clk);
        @(posedge clk);
        #1;
        pop_check();
        pop_check();
    endtask

    task automatic run(input logic e3, input logic e4, input string name);
        model_push(3, e3, name);
        model_push(4, e4, name);
        cycle(e3, e4);
    endtask

    task automatic check_reset_now(input string name);
        exp_t e;
        e.dut = 3; e.count = 4'd7;  e.tc = 1'b0; e.uf = 1'b0; e.name = name;
        check_out(e);
        e.dut = 4; e.count = 4'd15;
        check_out(e);
    endtask

    // Called just after a posedge: reset lands and releases between clock edges.
    task automatic async_reset(input string name);
        #2 rst = 1'b1;
        #1 check_reset_now(name);
        #2 rst = 1'b0;
        m3 = 4'd7;
        m4 = 4'd15;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog @%0t: got timeout, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'd6, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd5, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 4'd4, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 4'd3, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 4'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 4'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'd0, 1'b1, 1'b0};
`ifdef RIPPLE_DOWN_STOP_AT_ZERO_EN
        vecs[7]  = '{1'b1, 4'd0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 4'd0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 4'd0, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 4'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 4'd0, 1'b1, 1'b0};
`else
        vecs[7]  = '{1'b1, 4'd7, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 4'd6, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'd5, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'd4, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 4'd3, 1'b0, 1'b0};
`endif

        #1 rst = 1'b1;
        #2 check_reset_now("reset_state");
        #5 rst = 1'b0;

        // Table: WIDTH=3 enabled from reset; WIDTH=4 held idle alongside.
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            e.dut = 3; e.count = vecs[i].count; e.tc = vecs[i].tc; e.uf = vecs[i].uf;
            e.name = $sformatf("table_%0d", i);
            sb_q.push_back(e);
            model_push(4, 1'b0, e.name);
            m3 = vecs[i].count;
            cycle(vecs[i].en, 1'b0);
        end

        async_reset("reset_after_table");
        for (int i = 0; i < 3; i++) run(1'b1, 1'b0, "to_four");
        for (int i = 0; i < 5; i++) run(1'b0, 1'b0, "hold_four");
        for (int i = 0; i < 2; i++) run(1'b1, 1'b0, "resume");

        async_reset("reset_mid_count");
        for (int i = 0; i < 7; i++) run(1'b1, 1'b1, "restart");
        for (int i = 0; i < 3; i++) run(1'b0, 1'b0, "hold_zero");
        run(1'b1, 1'b1, "wrap_after_hold");
        run(1'b1, 1'b1, "after_wrap");

        for (int i = 0; i < 100; i++) begin
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random_en");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
